// File: rtl/inst_fetch_prefetch.sv
// -----------------------------------------------------------------------------
// inst_fetch_prefetch
//
// Instruction-fetch front end. Owns the fetch PC, presents the word address to
// the instruction SRAM controller and captures the returned word in the same
// cycle into a small prefetch FIFO of {pc, inst[, exc]} entries. Decode pops
// the FIFO head. A redirect flushes the FIFO and restarts fetch at a new PC.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, 2..16)
//   RESET_PC  fetch PC after reset
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   ramAddr_o     word address to SRAM controller (fetch PC [21:2])
//   instData_i    instruction word for ramAddr_o, valid in the same cycle
//   ramBusy_i     SRAM borrowed by the memory stage; instData_i is invalid
//   redirect_i    flush the FIFO and restart fetch
//   redirectPc_i  new fetch PC, sampled while redirect_i = 1
//   instValid_o   FIFO head valid
//   inst_o        FIFO head instruction
//   pc_o          FIFO head PC
//   excAddr_o     FIFO head carries a fetch address-error flag
//                 (only when IF_ADDR_ERR_EN is defined)
//   instReady_i   decode accepts the head this cycle
//
// Optional feature macro: IF_ADDR_ERR_EN
//   Defined:   a misaligned redirect target produces one error entry
//              (inst = 0, exc = 1) and halts fetch until the next redirect.
//   Undefined: redirect targets are silently word-aligned.
//
// Handshake: the head entry transfers on every rising edge where
// instValid_o = 1 and instReady_i = 1. instValid_o never depends on
// instReady_i, and a transfer coinciding with redirect_i is discarded
// (decode flushes in that same cycle).
// -----------------------------------------------------------------------------
module inst_fetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [19:0] ramAddr_o,
    input  logic [31:0] instData_i,
    input  logic        ramBusy_i,
    input  logic        redirect_i,
    input  logic [31:0] redirectPc_i,
    output logic        instValid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
`ifdef IF_ADDR_ERR_EN
    output logic        excAddr_o,
`endif
    input  logic        instReady_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_mem_q   [DEPTH];
    logic [31:0]    inst_mem_q [DEPTH];

    logic           halted;
    logic           err_pend;
    logic           full;
    logic           push;
    logic           pop;
    logic [31:0]    wr_inst;

`ifdef IF_ADDR_ERR_EN
    logic             halted_q, halted_d;
    logic             err_pend_q, err_pend_d;
    logic [DEPTH-1:0] exc_mem_q;

    assign halted   = halted_q;
    assign err_pend = err_pend_q;
`else
    assign halted   = 1'b0;
    assign err_pend = 1'b0;
`endif

    assign full        = (count_q == CW'(DEPTH));
    assign instValid_o = (count_q != '0);
    assign pop         = instValid_o & instReady_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle,
    // which keeps throughput at one word per cycle.
    assign push        = !redirect_i && !ramBusy_i && !halted && (!full || pop);

    // The error entry carries no instruction; the SRAM word is ignored.
    assign wr_inst     = err_pend ? 32'h0 : instData_i;

    assign ramAddr_o   = fetch_pc_q[21:2];
    assign inst_o      = inst_mem_q[rd_ptr_q];
    assign pc_o        = pc_mem_q[rd_ptr_q];
`ifdef IF_ADDR_ERR_EN
    assign excAddr_o   = exc_mem_q[rd_ptr_q];
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = redirectPc_i & 32'hFFFF_FFFC;
`ifdef IF_ADDR_ERR_EN
            // Keep the misaligned PC so the error entry reports it verbatim.
            if (redirectPc_i[1:0] != 2'b00) begin
                fetch_pc_d = redirectPc_i;
            end
`endif
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            // The error push halts fetch, so the PC stays on the bad address.
            if (push && !err_pend) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IF_ADDR_ERR_EN
    always_comb begin
        halted_d   = halted_q;
        err_pend_d = err_pend_q;
        if (redirect_i) begin
            halted_d   = 1'b0;
            err_pend_d = (redirectPc_i[1:0] != 2'b00);
        end else if (push && err_pend_q) begin
            halted_d   = 1'b1;
            err_pend_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
                inst_mem_q[wr_ptr_q] <= wr_inst;
            end
        end
    end

`ifdef IF_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q   <= 1'b0;
            err_pend_q <= 1'b0;
            exc_mem_q  <= '0;
        end else begin
            halted_q   <= halted_d;
            err_pend_q <= err_pend_d;
            if (push) begin
                exc_mem_q[wr_ptr_q] <= err_pend_q;
            end
        end
    end
`endif

endmodule

// File: doc/inst_fetch_prefetch.md
# inst_fetch_prefetch

Instruction-fetch front end that owns the fetch PC and drives the word address into the instruction SRAM controller. It captures the returned instruction word in the same cycle and queues {pc, instruction} pairs in a small prefetch FIFO. The decode stage pops entries with a valid/ready handshake. Branch/exception redirects flush the queue and restart fetch at a new PC.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `RESET_PC`, default 32'h8000_0000: fetch PC after reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ramAddr_o`  out  20  word address to the instruction SRAM controller; always equal to `fetchPc[21:2]`.
- `instData_i`  in  32  instruction word returned by the SRAM controller for `ramAddr_o`; valid in the same cycle.
- `ramBusy_i`  in  1  instruction SRAM is borrowed by the memory stage this cycle; the returned word is invalid.
- `redirect_i`  in  1  flush and restart fetch.
- `redirectPc_i`  in  32  new fetch PC, sampled when `redirect_i`=1.
- `instValid_o`  out  1  FIFO head is valid.
- `inst_o`  out  32  FIFO head instruction.
- `pc_o`  out  32  FIFO head PC.
- `instReady_i`  in  1  decode accepts the head this cycle.
- `excAddr_o`  out  1  head entry carries a fetch address-error flag. Present only with `IF_ADDR_ERR_EN`.

## Operation
- Registers: `fetchPc`[31:0], FIFO storage of DEPTH × {pc, inst, exc}, read pointer, write pointer and `count` (0..DEPTH), and, with the macro only, `halted`.
- `pop` = `instValid_o` & `instReady_i`.
- `push` = !`redirect_i` & !`ramBusy_i` & !`halted` & (`count` < DEPTH | `pop`).
- On push:
  - Write {`fetchPc`, `instData_i`, 0} at the write pointer.
  - Increment the write pointer modulo DEPTH.
  - `fetchPc` <= `fetchPc` + 4. The add wraps modulo 2^32 and needs no special case.
- On pop: increment the read pointer modulo DEPTH.
- `count` update: push only +1, pop only −1, both or neither unchanged. Simultaneous push and pop is legal when full and when empty+pop is impossible (pop requires `count`≠0).
- `instValid_o` = (`count` ≠ 0). `inst_o`, `pc_o` and `excAddr_o` come combinationally from the head entry.
- Redirect has highest priority.
  - In the redirect cycle, pointers and `count` clear, no push occurs, and any concurrent pop is discarded. Decode flushes in the same cycle.
  - `fetchPc` <= `redirectPc_i` & 32'hFFFF_FFFC, unless the macro path below applies.
- `ramBusy_i`=1: no push and `fetchPc` holds. The pop path is unaffected.

## Timing
- Reset values: `fetchPc`=RESET_PC, `count`=0, pointers=0, `halted`=0.
- Consequences after the reset edge: `instValid_o`=0, `inst_o`/`pc_o`=0 (storage cleared), `excAddr_o`=0, `ramAddr_o`=RESET_PC[21:2].
- Reset during any operation discards all queued entries and any pending redirect.
- Fetch latency: address at cycle N, entry visible at `instValid_o` in cycle N+1. It is poppable in N+1.
- Redirect at cycle R: `ramAddr_o`=new PC[21:2] in R+1, and the first new entry is valid in R+2.
- Steady-state throughput: 1 instruction/cycle while `instReady_i`=1 and `ramBusy_i`=0. Full FIFO with a continuous pop still sustains 1/cycle.
- The path `instData_i` -> FIFO write is single-cycle and has no combinational path to any output.

## Configuration
- `IF_ADDR_ERR_EN` defined:
  - A redirect with `redirectPc_i[1:0]`≠0 sets `fetchPc`=`redirectPc_i` unmasked and marks an error pending.
  - The next eligible push writes {`fetchPc`, 32'h0, 1} and sets `halted`=1.
  - While `halted`=1 no further fetch occurs and `ramAddr_o` holds.
  - Only a redirect or `rst` clears `halted`. A redirect to an aligned PC resumes normal fetch.
  - Port `excAddr_o` exists.
- `IF_ADDR_ERR_EN` undefined:
  - Redirect targets are silently word-aligned by masking bits [1:0].
  - `halted` is tied 0 and `excAddr_o` is absent.

## Test plan
- Reset, `instReady_i`=1, SRAM model returning word=addr: entries (8000_0000, 0000_0000), (8000_0004, 0000_0001), … one per cycle starting 1 cycle after reset release.
- `instReady_i`=0 for 10 cycles: `count` saturates at 4, `fetchPc` stops at 8000_0010. Releasing ready gives 8000_0000..8000_000C, then 8000_0010, with no gap and no duplicates.
- Full FIFO with ready=1 and a simultaneous push: `count` stays 4 and the PC sequence is contiguous.
- `ramBusy_i` high for 3 cycles mid-stream: no entries are written, `ramAddr_o` holds, and the stream resumes at the held PC with no skipped word.
- `redirect_i`=1, `redirectPc_i`=8000_0100 while 3 entries are queued and ready=1: `instValid_o`=0 next cycle, `ramAddr_o`=0x00040, and the next entry is pc 8000_0100.
- With `IF_ADDR_ERR_EN`, redirect to 8000_0102: a single entry appears with pc=8000_0102, `excAddr_o`=1, inst=0; no further entries follow. A redirect to 8000_0200 resumes fetch.
